// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART frame controller that sequences start/data/parity/stop
// around an external serializer and muxes the bits onto TX_OUT.
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] ser_p_data,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  tx_err
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_err_q, tx_err_d;
    logic                  accept;

    // A new byte is taken in IDLE or on the final stop bit, giving gapless back-to-back frames.
    assign accept = Data_Valid & ((state_q == IDLE) | ((state_q == STOP) & (stop_cnt_q == LAST_STOP)));

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_err_d   = 1'b0;
        unique case (state_q)
            IDLE: ;
            START: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (ser_done != (bit_cnt_q == LAST_BIT)) begin
                    state_d  = IDLE;
                    tx_err_d = 1'b1;
                end else if (ser_done) begin
                    state_d    = par_en_q ? PARITY : STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            PARITY: begin
                state_d    = STOP;
                stop_cnt_d = 1'b0;
            end
            STOP: begin
                stop_cnt_d = stop_cnt_q + 1'b1;
                if (stop_cnt_q == LAST_STOP) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d   = START;
            data_d    = P_DATA;
            par_en_d  = PAR_EN;
            par_bit_d = ^P_DATA ^ PAR_TYP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign ser_en     = (state_q == START) | (state_q == DATA);
    assign busy       = state_q != IDLE;
    assign tx_err     = tx_err_q;
    assign ser_p_data = data_q;
    assign TX_OUT     = (state_q == START)  ? 1'b0 :
                        (state_q == DATA)   ? ser_data :
                        (state_q == PARITY) ? par_bit_q : 1'b1;
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed bench for uart_tx_fsm with one- and two-stop-bit
// instances, each paired with a behavioural 8-bit serializer.
module tb_uart_tx_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       dv = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       inj = 1'b0;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        logic       ser_en, ser_data, ser_done, tx_out, busy, tx_err;
        logic [7:0] spd;
        logic [2:0] s_cnt;
        logic       s_act, s_done, s_bit;

        uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(g + 1)) dut (
            .clk(clk), .reset(reset), .P_DATA(p_data), .Data_Valid(dv),
            .PAR_EN(par_en), .PAR_TYP(par_typ), .ser_data(ser_data),
            .ser_done(ser_done), .ser_en(ser_en), .ser_p_data(spd),
            .TX_OUT(tx_out), .busy(busy), .tx_err(tx_err)
        );

        // Serializer: loads LSB on the first enabled edge, flags done alongside the last bit.
        always_ff @(posedge clk) begin
            if (!reset || !ser_en) begin
                s_act  <= 1'b0;
                s_done <= 1'b0;
                s_cnt  <= 3'd0;
                s_bit  <= 1'b0;
            end else if (!s_act || s_done) begin
                s_act  <= 1'b1;
                s_cnt  <= 3'd0;
                s_bit  <= spd[0];
                s_done <= 1'b0;
            end else begin
                s_cnt  <= s_cnt + 3'd1;
                s_bit  <= spd[s_cnt + 3'd1];
                s_done <= (s_cnt == 3'd6);
            end
        end
        assign ser_data = s_bit;
        assign ser_done = s_done | inj;
    end

    task automatic settle();
        dv = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        compared++;
        if (u[0].tx_out !== 1'b1 || u[0].busy !== 1'b0 || u[0].ser_en !== 1'b0 || u[0].tx_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset0 got tx=%b busy=%b en=%b err=%b want 1 0 0 0", u[0].tx_out, u[0].busy, u[0].ser_en, u[0].tx_err);
        end
        compared++;
        if (u[1].tx_out !== 1'b1 || u[1].busy !== 1'b0 || u[0].spd !== 8'h00) begin
            mismatched++;
            $display("FAIL reset1 got tx=%b busy=%b spd=%h want 1 0 00", u[1].tx_out, u[1].busy, u[0].spd);
        end
        reset = 1'b1;
        settle();
    endtask

    task automatic test_even_parity();
        logic [0:10] e = 11'b0_10100101_0_1;
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            compared++;
            if (u[0].busy !== (k < 11)) begin
                mismatched++;
                $display("FAIL even_busy k=%0d got %b want %b", k, u[0].busy, k < 11);
            end
            compared++;
            if (u[0].ser_en !== (k < 9)) begin
                mismatched++;
                $display("FAIL even_ser_en k=%0d got %b want %b", k, u[0].ser_en, k < 9);
            end
            compared++;
            if (u[0].tx_out !== ((k < 11) ? e[k] : 1'b1)) begin
                mismatched++;
                $display("FAIL even_tx k=%0d got %b want %b", k, u[0].tx_out, (k < 11) ? e[k] : 1'b1);
            end
        end
        settle();
    endtask

    task automatic test_odd_parity();
        logic [0:10] e = 11'b0_10100101_1_1;
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b1; dv = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            compared++;
            if (u[0].tx_out !== e[k]) begin
                mismatched++;
                $display("FAIL odd_tx k=%0d got %b want %b", k, u[0].tx_out, e[k]);
            end
        end
        settle();
    endtask

    task automatic test_no_parity();
        logic [0:10] e = 11'b0_10100101_1_1;
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            compared++;
            if (u[0].tx_out !== e[k] || u[0].busy !== (k < 10)) begin
                mismatched++;
                $display("FAIL nopar k=%0d got tx=%b busy=%b want tx=%b busy=%b", k, u[0].tx_out, u[0].busy, e[k], k < 10);
            end
        end
        settle();
    endtask

    task automatic test_back_to_back();
        logic [0:20] e = 21'b0_00111100_1_0_11111111_1_1;
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            compared++;
            if (u[0].tx_out !== e[k] || u[0].busy !== (k < 20)) begin
                mismatched++;
                $display("FAIL b2b k=%0d got tx=%b busy=%b want tx=%b busy=%b", k, u[0].tx_out, u[0].busy, e[k], k < 20);
            end
            if (k == 9) p_data = 8'hFF;
            if (k == 10) dv = 1'b0;
        end
        settle();
    endtask

    task automatic test_two_stop();
        logic [0:11] e = 12'b0_00000000_11_1;
        p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            compared++;
            if (u[1].tx_out !== e[k] || u[1].busy !== (k < 11)) begin
                mismatched++;
                $display("FAIL stop2 k=%0d got tx=%b busy=%b want tx=%b busy=%b", k, u[1].tx_out, u[1].busy, e[k], k < 11);
            end
        end
        settle();
    endtask

    task automatic test_config_change();
        logic [0:10] e = 11'b0_10100101_0_1;
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            compared++;
            if (u[0].tx_out !== e[k] || u[0].spd !== 8'hA5) begin
                mismatched++;
                $display("FAIL cfg k=%0d got tx=%b spd=%h want tx=%b spd=a5", k, u[0].tx_out, u[0].spd, e[k]);
            end
            if (k == 3) begin dv = 1'b1; p_data = 8'h00; par_typ = 1'b1; par_en = 1'b0; end
            if (k == 4) dv = 1'b0;
        end
        settle();
    endtask

    task automatic test_reset_mid_frame();
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            if (k == 5) begin
                compared++;
                if (u[0].tx_out !== 1'b0 || u[0].busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL rst_bit4 got tx=%b busy=%b want 0 1", u[0].tx_out, u[0].busy);
                end
                reset = 1'b0;
            end
            if (k == 6) begin
                compared++;
                if (u[0].tx_out !== 1'b1 || u[0].busy !== 1'b0 || u[0].ser_en !== 1'b0) begin
                    mismatched++;
                    $display("FAIL rst_abort got tx=%b busy=%b en=%b want 1 0 0", u[0].tx_out, u[0].busy, u[0].ser_en);
                end
                reset = 1'b1;
            end
            if (k == 7) begin
                compared++;
                if (u[0].spd !== 8'h00 || u[0].busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL rst_clear got spd=%h busy=%b want 00 0", u[0].spd, u[0].busy);
                end
            end
        end
        settle();
    endtask

    task automatic test_handshake_error();
        p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; dv = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) dv = 1'b0;
            if (k == 4) begin
                compared++;
                if (u[0].tx_err !== 1'b0 || u[0].tx_out !== 1'b0) begin
                    mismatched++;
                    $display("FAIL err_pre got err=%b tx=%b want 0 0", u[0].tx_err, u[0].tx_out);
                end
                inj = 1'b1;
            end
            if (k == 5) begin
                inj = 1'b0;
                compared++;
                if (u[0].tx_err !== 1'b1 || u[0].busy !== 1'b0 || u[0].tx_out !== 1'b1) begin
                    mismatched++;
                    $display("FAIL err_pulse got err=%b busy=%b tx=%b want 1 0 1", u[0].tx_err, u[0].busy, u[0].tx_out);
                end
            end
            if (k == 6) begin
                compared++;
                if (u[0].tx_err !== 1'b0 || u[0].busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL err_clear got err=%b busy=%b want 0 0", u[0].tx_err, u[0].busy);
                end
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_two_stop();
        test_config_change();
        test_reset_mid_frame();
        test_handshake_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
